tx_seq_ctrl: RTL and testbench

Parametrised UART transmit sequencer, successor to the fixed 4-byte result transmitter. It latches a result word of up to MAX_BYTES bytes and feeds the UART transmitter one byte per handshake. Each transfer carries a per-transfer byte count and byte order, and adds an acknowledge timeout and a programmable inter-byte gap. It sits between the command control unit (which supplies the result word and length) and the UART TX core.

---
 rtl/tx_seq_pkg.sv | 17 +
 rtl/tx_byte_sel.sv | 25 ++
 rtl/tx_seq_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_tx_seq_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_seq_pkg.sv
// Shared types and default constants for the UART transmit sequencer.
package tx_seq_pkg;

  localparam int unsigned REGISTER_DELAY = 100;
  localparam int unsigned INTER_BYTE_GAP = 0;

  typedef enum logic [2:0] {
    StIdle,
    StRegister,
    StSend,
    StWaitAck,
    StWaitDone,
    StGap,
    StDone
  } tx_seq_state_t;

endpackage

// File: rtl/tx_byte_sel.sv
// Combinational pick of the byte to transmit for a given position in the transfer.
module tx_byte_sel #(
  parameter int unsigned MAX_BYTES = 4,
  parameter int unsigned CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic [8*MAX_BYTES-1:0] i_word,
  input  logic [CNT_W-1:0]       i_n,
  input  logic [CNT_W-1:0]       i_idx,
  input  logic                   i_msb_first,
  output logic [7:0]             o_byte
);

  logic [CNT_W-1:0] w_k;

  always_comb begin
    w_k    = i_msb_first ? (i_n - CNT_W'(1) - i_idx) : i_idx;
    o_byte = 8'h00;
    for (int i = 0; i < int'(MAX_BYTES); i++) begin
      if (w_k == CNT_W'(i)) begin
        o_byte = i_word[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/tx_seq_ctrl.sv
// UART transmit sequencer: latches a result word and hands it to the UART TX one byte per
// start/busy handshake, with per-transfer length and byte order, ack timeout and inter-byte gap.
module tx_seq_ctrl #(
  parameter int unsigned MAX_BYTES      = 4,
  parameter int unsigned REGISTER_DELAY = tx_seq_pkg::REGISTER_DELAY,
  parameter int unsigned INTER_BYTE_GAP = tx_seq_pkg::INTER_BYTE_GAP,
  parameter int unsigned ACK_TIMEOUT    = 16,
  parameter int unsigned CNT_W          = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   begin_transmission,
  input  logic [CNT_W-1:0]       byte_count,
  input  logic                   msb_first,
  input  logic [8*MAX_BYTES-1:0] data_in,
  input  logic                   tx_busy,
  output logic                   register_result,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  output logic                   tx_sent,
  output logic                   tx_error,
  output logic                   busy
);
  import tx_seq_pkg::*;

  localparam int unsigned TMAX_A  = (REGISTER_DELAY > ACK_TIMEOUT) ? REGISTER_DELAY : ACK_TIMEOUT;
  localparam int unsigned TMAX    = (TMAX_A > INTER_BYTE_GAP) ? TMAX_A : INTER_BYTE_GAP;
  localparam int unsigned TIMER_W = $clog2(TMAX + 1);
  localparam int unsigned GAP_M1  = (INTER_BYTE_GAP > 0) ? INTER_BYTE_GAP - 1 : 32'd0;

  localparam logic [TIMER_W-1:0] REG_END = TIMER_W'(REGISTER_DELAY);
  localparam logic [TIMER_W-1:0] ACK_END = TIMER_W'(ACK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] GAP_END = TIMER_W'(GAP_M1);
  localparam logic [CNT_W-1:0]   MAX_N   = CNT_W'(MAX_BYTES);

  tx_seq_state_t          r_state;
  logic [TIMER_W-1:0]     r_timer;
  logic [CNT_W-1:0]       r_n;
  logic [CNT_W-1:0]       r_byte_idx;
  logic                   r_msb_first;
  logic [8*MAX_BYTES-1:0] r_word;
  logic                   r_register_result;
  logic                   r_tx_start;
  logic [7:0]             r_tx_data;
  logic                   r_tx_sent;
  logic                   r_tx_error;
  logic                   r_busy;

  logic [CNT_W-1:0]       w_n_clamped;
  logic [CNT_W-1:0]       w_idx_inc;
  logic [8*MAX_BYTES-1:0] w_sel_word;
  logic [CNT_W-1:0]       w_sel_idx;
  logic [7:0]             w_sel_byte;

  assign w_n_clamped = (byte_count > MAX_N) ? MAX_N : byte_count;
  assign w_idx_inc   = r_byte_idx + CNT_W'(1);

  // tx_data is loaded on the edge that enters SEND, so select from the word/index that
  // SEND will use: live data_in for the first byte, the incremented index after a byte.
  always_comb begin
    w_sel_word = r_word;
    w_sel_idx  = r_byte_idx;
    if (r_state == StRegister) begin
      w_sel_word = data_in;
      w_sel_idx  = '0;
    end else if (r_state == StWaitDone) begin
      w_sel_idx = w_idx_inc;
    end
  end

  tx_byte_sel #(
    .MAX_BYTES(MAX_BYTES),
    .CNT_W    (CNT_W)
  ) u_byte_sel (
    .i_word     (w_sel_word),
    .i_n        (r_n),
    .i_idx      (w_sel_idx),
    .i_msb_first(r_msb_first),
    .o_byte     (w_sel_byte)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state           <= StIdle;
      r_timer           <= '0;
      r_n               <= '0;
      r_byte_idx        <= '0;
      r_msb_first       <= 1'b0;
      r_word            <= '0;
      r_register_result <= 1'b0;
      r_tx_start        <= 1'b0;
      r_tx_data         <= 8'h00;
      r_tx_sent         <= 1'b0;
      r_tx_error        <= 1'b0;
      r_busy            <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_tx_sent  <= 1'b0;
      r_tx_error <= 1'b0;
      r_timer    <= r_timer + TIMER_W'(1);
      unique case (r_state)
        StIdle: begin
          r_timer <= '0;
          if (begin_transmission) begin
            r_n         <= w_n_clamped;
            r_msb_first <= msb_first;
            r_busy      <= 1'b1;
            if (w_n_clamped == '0) begin
              r_state   <= StDone;
              r_tx_sent <= 1'b1;
            end else begin
              r_state           <= StRegister;
              r_register_result <= 1'b1;
            end
          end
        end
        StRegister: begin
          if (r_timer == REG_END) begin
            r_word            <= data_in;
            r_byte_idx        <= '0;
            r_timer           <= '0;
            r_register_result <= 1'b0;
            r_state           <= StSend;
            r_tx_start        <= 1'b1;
            r_tx_data         <= w_sel_byte;
          end
        end
        StSend: begin
          r_state <= StWaitAck;
          r_timer <= '0;
        end
        StWaitAck: begin
          if (tx_busy) begin
            r_state <= StWaitDone;
            r_timer <= '0;
          end else if (r_timer == ACK_END) begin
            r_state    <= StDone;
            r_timer    <= '0;
            r_tx_sent  <= 1'b1;
            r_tx_error <= 1'b1;
          end
        end
        StWaitDone: begin
          if (!tx_busy) begin
            r_byte_idx <= w_idx_inc;
            r_timer    <= '0;
            if (w_idx_inc == r_n) begin
              r_state   <= StDone;
              r_tx_sent <= 1'b1;
            end else if (INTER_BYTE_GAP > 0) begin
              r_state <= StGap;
            end else begin
              r_state    <= StSend;
              r_tx_start <= 1'b1;
              r_tx_data  <= w_sel_byte;
            end
          end
        end
        StGap: begin
          if (r_timer == GAP_END) begin
            r_state    <= StSend;
            r_timer    <= '0;
            r_tx_start <= 1'b1;
            r_tx_data  <= w_sel_byte;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_timer <= '0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state           <= StIdle;
          r_timer           <= '0;
          r_busy            <= 1'b0;
          r_register_result <= 1'b0;
        end
      endcase
    end
  end

  assign register_result = r_register_result;
  assign tx_start        = r_tx_start;
  assign tx_data         = r_tx_data;
  assign tx_sent         = r_tx_sent;
  assign tx_error        = r_tx_error;
  assign busy            = r_busy;

endmodule

// File: tb/tb_tx_seq_ctrl.sv
// Randomised self-checking bench for tx_seq_ctrl with a simple UART busy model.
module tb_tx_seq_ctrl;

  localparam int MB  = 4;
  localparam int RD  = 8;
  localparam int GAP = 5;
  localparam int ACK = 16;
  localparam int CW  = $clog2(MB + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          begin_transmission = 1'b0;
  logic [CW-1:0] byte_count = '0;
  logic          msb_first = 1'b0;
  logic [31:0]   data_in = '0;
  logic          tx_busy = 1'b0;
  logic          register_result, tx_start, tx_sent, tx_error, busy;
  logic [7:0]    tx_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // UART model / monitor state
  bit         uart_en = 1'b1;
  int         busy_len = 10;
  int         busy_cnt = 0;
  logic [7:0] q_bytes[$];
  int         q_start[$];
  int         n_sent = 0, n_err = 0, sent_cyc = -1, err_cyc = -1, n_reg = 0, first_reg = -1;

  tx_seq_ctrl #(
    .MAX_BYTES     (MB),
    .REGISTER_DELAY(RD),
    .INTER_BYTE_GAP(GAP),
    .ACK_TIMEOUT   (ACK)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .begin_transmission(begin_transmission),
    .byte_count        (byte_count),
    .msb_first         (msb_first),
    .data_in           (data_in),
    .tx_busy           (tx_busy),
    .register_result   (register_result),
    .tx_start          (tx_start),
    .tx_data           (tx_data),
    .tx_sent           (tx_sent),
    .tx_error          (tx_error),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Busy is raised in the tx_start cycle and held for busy_len sampling edges.
  always @(negedge clk) begin
    if (!reset_n) begin
      busy_cnt = 0;
      tx_busy  = 1'b0;
    end else begin
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) tx_busy = 1'b0;
      end
      if (tx_start) begin
        q_bytes.push_back(tx_data);
        q_start.push_back(cyc);
        if (uart_en) begin
          busy_cnt = busy_len;
          tx_busy  = 1'b1;
        end
      end
      if (tx_sent) begin
        n_sent++;
        sent_cyc = cyc;
      end
      if (tx_error) begin
        n_err++;
        err_cyc = cyc;
      end
      if (register_result) begin
        if (n_reg == 0) first_reg = cyc;
        n_reg++;
      end
    end
  end

  function automatic int clamp_n(input int cnt);
    return (cnt > MB) ? MB : cnt;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [31:0] w, input int n, input int j,
                                          input bit msb);
    int k;
    k = msb ? (n - 1 - j) : j;
    return 8'((w >> (8 * k)) & 32'hFF);
  endfunction

  task automatic clear_mon();
    q_bytes.delete();
    q_start.delete();
    n_sent = 0; n_err = 0; sent_cyc = -1; err_cyc = -1; n_reg = 0; first_reg = -1;
  endtask

  task automatic run_xfer(input logic [31:0] w, input int cnt, input bit msb,
                          input bit scramble, output int b);
    int guard;
    @(posedge clk); #1;
    clear_mon();
    @(negedge clk); #1;
    data_in = w; byte_count = cnt[CW-1:0]; msb_first = msb; begin_transmission = 1'b1;
    b = cyc;
    @(negedge clk); #1;
    begin_transmission = 1'b0;
    guard = 0;
    while (n_sent == 0 && guard < 3000) begin
      if (scramble && q_start.size() > 0) data_in = $urandom;
      @(negedge clk); #1;
      guard++;
    end
    if (n_sent == 0) begin
      total++; bad++;
      $display("FAIL xfer_done: tx_sent count=0 after %0d cycles, required 1", guard);
    end
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({register_result, tx_start, tx_sent, tx_error, busy} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b required 00000",
               {register_result, tx_start, tx_sent, tx_error, busy});
    end
    total++;
    if (tx_data !== 8'h00) begin
      bad++; $display("FAIL reset_tx_data: got %h required 00", tx_data);
    end
    @(negedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({busy, tx_start, register_result} !== 3'b0) begin
      bad++; $display("FAIL idle_after_reset: got %b required 000",
                      {busy, tx_start, register_result});
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] exp[4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    int b;
    busy_len = 10;
    run_xfer(32'hA1B2C3D4, 4, 1'b0, 1'b0, b);
    total++;
    if (q_bytes.size() != 4) begin
      bad++; $display("FAIL lsb_count: got %0d bytes required 4", q_bytes.size());
    end
    for (int j = 0; j < 4 && j < q_bytes.size(); j++) begin
      total++;
      if (q_bytes[j] !== exp[j]) begin
        bad++; $display("FAIL lsb_byte%0d: got %h required %h", j, q_bytes[j], exp[j]);
      end
    end
    total++;
    if (n_sent != 1 || n_err != 0) begin
      bad++; $display("FAIL lsb_status: sent=%0d err=%0d required 1 0", n_sent, n_err);
    end
    total++;
    if (first_reg != b + 1 || n_reg != RD + 1) begin
      bad++; $display("FAIL lsb_register: first=%0d len=%0d required %0d %0d",
                      first_reg, n_reg, b + 1, RD + 1);
    end
    if (q_start.size() > 0) begin
      total++;
      if (q_start[0] != b + RD + 2) begin
        bad++; $display("FAIL lsb_first_start: got %0d required %0d", q_start[0], b + RD + 2);
      end
    end
  endtask

  task automatic test_msb_partial();
    int b;
    busy_len = 6;
    run_xfer(32'hA1B2C3D4, 2, 1'b1, 1'b0, b);
    total++;
    if (q_bytes.size() != 2) begin
      bad++; $display("FAIL msb_count: got %0d bytes required 2", q_bytes.size());
    end else begin
      total++;
      if (q_bytes[0] !== 8'hC3 || q_bytes[1] !== 8'hD4) begin
        bad++; $display("FAIL msb_bytes: got %h %h required c3 d4", q_bytes[0], q_bytes[1]);
      end
      total++;
      if (sent_cyc != q_start[1] + busy_len + 1) begin
        bad++; $display("FAIL msb_sent_time: got %0d required %0d",
                        sent_cyc, q_start[1] + busy_len + 1);
      end
    end
  endtask

  task automatic test_zero_count();
    int b;
    run_xfer($urandom, 0, 1'b0, 1'b0, b);
    total++;
    if (q_start.size() != 0 || n_reg != 0) begin
      bad++; $display("FAIL zero_activity: starts=%0d reg_cycles=%0d required 0 0",
                      q_start.size(), n_reg);
    end
    total++;
    if (n_sent != 1 || sent_cyc != b + 1) begin
      bad++; $display("FAIL zero_sent: count=%0d at %0d required 1 at %0d",
                      n_sent, sent_cyc, b + 1);
    end
  endtask

  task automatic test_clamp_gap();
    logic [31:0] w;
    int b;
    w = $urandom;
    busy_len = 4;
    run_xfer(w, 7, 1'b0, 1'b0, b);
    total++;
    if (q_bytes.size() != 4) begin
      bad++; $display("FAIL clamp_count: got %0d bytes required 4", q_bytes.size());
    end
    for (int j = 0; j < q_bytes.size() && j < 4; j++) begin
      total++;
      if (q_bytes[j] !== exp_byte(w, 4, j, 1'b0)) begin
        bad++; $display("FAIL clamp_byte%0d: got %h required %h", j, q_bytes[j],
                        exp_byte(w, 4, j, 1'b0));
      end
      if (j > 0) begin
        total++;
        if (q_start[j] - q_start[j-1] != busy_len + GAP + 1) begin
          bad++; $display("FAIL gap_spacing%0d: got %0d required %0d", j,
                          q_start[j] - q_start[j-1], busy_len + GAP + 1);
        end
      end
    end
  endtask

  task automatic test_ack_timeout();
    int b;
    uart_en = 1'b0;
    run_xfer($urandom, 3, 1'b0, 1'b0, b);
    uart_en = 1'b1;
    total++;
    if (q_start.size() != 1) begin
      bad++; $display("FAIL timeout_starts: got %0d required 1", q_start.size());
    end
    total++;
    if (n_err != 1 || n_sent != 1 || err_cyc != sent_cyc) begin
      bad++; $display("FAIL timeout_pulse: err=%0d@%0d sent=%0d@%0d required 1 1 together",
                      n_err, err_cyc, n_sent, sent_cyc);
    end
    if (q_start.size() > 0) begin
      total++;
      if (sent_cyc != q_start[0] + ACK + 1) begin
        bad++; $display("FAIL timeout_time: got %0d required %0d", sent_cyc,
                        q_start[0] + ACK + 1);
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] w2;
    int guard, b;
    busy_len = 10;
    @(posedge clk); #1;
    clear_mon();
    @(negedge clk); #1;
    data_in = 32'h11223344; byte_count = 3'd4; msb_first = 1'b0; begin_transmission = 1'b1;
    @(negedge clk); #1;
    begin_transmission = 1'b0;
    guard = 0;
    while (q_start.size() < 2 && guard < 500) begin
      @(negedge clk); #1;
      guard++;
    end
    total++;
    if (q_start.size() < 2) begin
      bad++; $display("FAIL midflight_reach: starts=%0d required 2", q_start.size());
    end
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if ({register_result, tx_start, tx_sent, tx_error, busy, tx_data} !== 13'b0) begin
      bad++; $display("FAIL midflight_outputs: got %b required all zero",
                      {register_result, tx_start, tx_sent, tx_error, busy, tx_data});
    end
    repeat (3) @(negedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (n_sent != 0) begin
      bad++; $display("FAIL midflight_no_sent: got %0d required 0", n_sent);
    end
    w2 = $urandom;
    run_xfer(w2, 4, 1'b0, 1'b0, b);
    total++;
    if (q_bytes.size() != 4 || n_sent != 1) begin
      bad++; $display("FAIL restart_count: bytes=%0d sent=%0d required 4 1",
                      q_bytes.size(), n_sent);
    end
    for (int j = 0; j < q_bytes.size() && j < 4; j++) begin
      total++;
      if (q_bytes[j] !== exp_byte(w2, 4, j, 1'b0)) begin
        bad++; $display("FAIL restart_byte%0d: got %h required %h", j, q_bytes[j],
                        exp_byte(w2, 4, j, 1'b0));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    int cnt, n, b;
    bit msb;
    for (int it = 0; it < 10; it++) begin
      w = $urandom;
      cnt = $urandom_range(0, 7);
      msb = 1'($urandom_range(0, 1));
      busy_len = $urandom_range(2, 12);
      n = clamp_n(cnt);
      run_xfer(w, cnt, msb, 1'b1, b);
      total++;
      if (q_bytes.size() != n || n_sent != 1 || n_err != 0 || busy !== 1'b0) begin
        bad++; $display("FAIL rnd%0d_summary: bytes=%0d sent=%0d err=%0d busy=%b required %0d 1 0 0",
                        it, q_bytes.size(), n_sent, n_err, busy, n);
      end
      for (int j = 0; j < q_bytes.size() && j < n; j++) begin
        total++;
        if (q_bytes[j] !== exp_byte(w, n, j, msb)) begin
          bad++; $display("FAIL rnd%0d_byte%0d: got %h required %h", it, j, q_bytes[j],
                          exp_byte(w, n, j, msb));
        end
        if (j > 0) begin
          total++;
          if (q_start[j] - q_start[j-1] != busy_len + GAP + 1) begin
            bad++; $display("FAIL rnd%0d_spacing%0d: got %0d required %0d", it, j,
                            q_start[j] - q_start[j-1], busy_len + GAP + 1);
          end
        end
      end
      total++;
      if (n == 0) begin
        if (sent_cyc != b + 1 || n_reg != 0) begin
          bad++; $display("FAIL rnd%0d_empty: sent@%0d reg=%0d required %0d 0",
                          it, sent_cyc, n_reg, b + 1);
        end
      end else if (q_start.size() != n || q_start[0] != b + RD + 2 ||
                   sent_cyc != q_start[n-1] + busy_len + 1 || n_reg != RD + 1) begin
        bad++; $display("FAIL rnd%0d_timing: starts=%0d first=%0d sent=%0d reg=%0d base=%0d",
                        it, q_start.size(), (q_start.size() > 0) ? q_start[0] : -1,
                        sent_cyc, n_reg, b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_partial();
    test_zero_count();
    test_clamp_gap();
    test_ack_timeout();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
